// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and fetch engine feeding decode through a small {pc, instr} FIFO.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 1024,
  parameter int unsigned DEPTH      = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fault,
  output logic [31:0] fetch_count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);
  typedef enum logic {RUN, FAULT} state_t;
  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   fetch_count_q, fetch_count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic          in_range, pop, push;
  assign imem_addr   = pc_q;
  assign out_valid   = count_q != '0;
  assign out_pc      = pc_mem[rd_ptr_q];
  assign out_instr   = instr_mem[rd_ptr_q];
  assign fault       = state_q == FAULT;
  assign fetch_count = fetch_count_q;
  assign in_range    = pc_q <= LAST_PC;
  assign pop         = out_valid & out_ready;
  assign push        = (state_q == RUN) & ~redirect_valid & in_range & ((count_q < CW'(DEPTH)) | pop);
  // A redirect flushes the FIFO; a coincident pop still counts as delivered.
  always_comb begin
    fetch_count_d = fetch_count_q + 32'(push);
    pc_d          = redirect_valid ? (redirect_pc & ~32'd3) : push ? pc_q + 32'd4 : pc_q;
    count_d       = redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
    wr_ptr_d      = redirect_valid ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d      = redirect_valid ? '0 : rd_ptr_q + PW'(pop);
    state_d       = redirect_valid ? RUN : (state_q == RUN && !in_range) ? FAULT : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= pc_q;
      instr_mem[wr_ptr_q] <= imem_data;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vectors against hand-computed fetch results.
module tb_instr_fetch_unit;
  logic        clk = 0;
  logic        rst = 1;
  logic [31:0] imem_addr, imem_data;
  logic        redirect_valid = 0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid, out_ready = 1;
  logic [31:0] out_pc, out_instr, fetch_count;
  logic        fault;
  logic [31:0] mem [256];
  int          n_vec = 0, n_bad = 0;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .fault(fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;
  assign imem_data = (imem_addr < 32'd1024) ? mem[imem_addr[9:2]] : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1;
    redirect_valid = 0;
    step();
    rst = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | (i * 4);
    mem[0] = 32'h0000_0f93;
    mem[1] = 32'h00f0_0313;
    mem[2] = 32'h001f_8f93;
    mem[6] = 32'h0040_006f;

    // reset state and sequential fetch
    out_ready = 1;
    step();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_count", fetch_count, 0);
    check("rst_addr", imem_addr, 0);
    rst = 0;
    step();
    check("seq0_valid", 32'(out_valid), 1);
    check("seq0_pc", out_pc, 32'h0);
    check("seq0_instr", out_instr, 32'h0000_0f93);
    step();
    check("seq1_pc", out_pc, 32'h4);
    check("seq1_instr", out_instr, 32'h00f0_0313);
    step();
    check("seq2_pc", out_pc, 32'h8);
    check("seq2_instr", out_instr, 32'h001f_8f93);
    check("seq_count", fetch_count, 3);

    // backpressure
    out_ready = 0;
    reset_dut();
    for (int i = 0; i < 5; i++) step();
    check("bp_valid", 32'(out_valid), 1);
    check("bp_head", out_pc, 32'h0);
    check("bp_addr", imem_addr, 32'h8);
    check("bp_count", fetch_count, 2);
    out_ready = 1;
    step();
    check("bp_d1", out_pc, 32'h4);
    step();
    check("bp_d2", out_pc, 32'h8);
    check("bp_d2_instr", out_instr, 32'h001f_8f93);
    step();
    check("bp_d3", out_pc, 32'hC);

    // redirect with two buffered entries; head pc 0 goes out in the redirect cycle
    out_ready = 0;
    reset_dut();
    step();
    step();
    out_ready = 1;
    redirect_valid = 1;
    redirect_pc = 32'h18;
    check("rd_head", out_pc, 32'h0);
    step();
    redirect_valid = 0;
    check("rd_flush", 32'(out_valid), 0);
    check("rd_addr", imem_addr, 32'h18);
    step();
    check("rd_valid", 32'(out_valid), 1);
    check("rd_pc", out_pc, 32'h18);
    check("rd_instr", out_instr, 32'h0040_006f);
    check("rd_count", fetch_count, 3);

    // misaligned redirect
    redirect_valid = 1;
    redirect_pc = 32'h13;
    step();
    redirect_valid = 0;
    step();
    check("mis_pc", out_pc, 32'h10);
    check("mis_instr", out_instr, 32'hC0DE_0010);

    // fault at the top of memory and recovery
    reset_dut();
    redirect_valid = 1;
    redirect_pc = 32'd1020;
    step();
    redirect_valid = 0;
    step();
    check("flt_pc", out_pc, 32'd1020);
    check("flt_pre", 32'(fault), 0);
    check("flt_cnt1", fetch_count, 1);
    step();
    check("flt_set", 32'(fault), 1);
    check("flt_empty", 32'(out_valid), 0);
    check("flt_addr", imem_addr, 32'd1024);
    step();
    step();
    check("flt_frozen", fetch_count, 1);
    check("flt_hold", 32'(fault), 1);
    redirect_valid = 1;
    redirect_pc = 32'h0;
    step();
    redirect_valid = 0;
    check("rec_fault", 32'(fault), 0);
    step();
    check("rec_pc", out_pc, 32'h0);
    check("rec_instr", out_instr, 32'h0000_0f93);
    check("rec_count", fetch_count, 2);

    // redirect straight to an out-of-range target
    redirect_valid = 1;
    redirect_pc = 32'd1024;
    step();
    redirect_valid = 0;
    check("oor_run", 32'(fault), 0);
    step();
    check("oor_fault", 32'(fault), 1);

    // reset with full FIFO and a redirect pending
    reset_dut();
    out_ready = 0;
    step();
    step();
    step();
    rst = 1;
    redirect_valid = 1;
    redirect_pc = 32'h40;
    step();
    check("mrst_valid", 32'(out_valid), 0);
    check("mrst_addr", imem_addr, 32'h0);
    check("mrst_fault", 32'(fault), 0);
    check("mrst_count", fetch_count, 0);
    rst = 0;
    redirect_valid = 0;
    step();
    check("mrst_pc", out_pc, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
